// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared constants and the RAM-side request record for the on-chip RAM arbiter.
// Pure types and constants; no logic, so no latency or backpressure of its own.
package onchip_mem_pkg;

    localparam int OCM_ADDR_W    = 15;
    localparam int OCM_DATA_W    = 32;
    localparam int OCM_BE_W      = OCM_DATA_W / 8;
    localparam int OCM_NUM_WORDS = 25000;

    typedef struct packed {
        logic [OCM_ADDR_W-1:0] address;
        logic [OCM_BE_W-1:0]   byteenable;
        logic                  read;
        logic                  write;
        logic [OCM_DATA_W-1:0] writedata;
    } ocm_req_t;

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM pipelined master/slave port with waitrequest and readdatavalid.
// Request holds while waitrequest is high; read data returns on readdatavalid.
interface onchip_mem_arbiter_if;

    logic [onchip_mem_pkg::OCM_ADDR_W-1:0] address;
    logic [onchip_mem_pkg::OCM_BE_W-1:0]   byteenable;
    logic                                  read;
    logic                                  write;
    logic [onchip_mem_pkg::OCM_DATA_W-1:0] writedata;
    logic                                  waitrequest;
    logic [onchip_mem_pkg::OCM_DATA_W-1:0] readdata;
    logic                                  readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the non-last master.
// Purely combinational, zero latency; losers are held off by the caller's waitrequest.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Round-robin share of one single-port on-chip RAM between two Avalon-MM masters.
// Zero-wait acceptance when granted, 1-cycle read return; loser sees waitrequest.
module onchip_mem_arbiter
    import onchip_mem_pkg::*;
#(
    parameter int ADDR_W    = OCM_ADDR_W,
    parameter int DATA_W    = OCM_DATA_W,
    parameter int BE_W      = OCM_BE_W,
    parameter int NUM_WORDS = OCM_NUM_WORDS
) (
    input  logic                 clk,
    input  logic                 reset,
    onchip_mem_arbiter_if.slave  m0,
    onchip_mem_arbiter_if.slave  m1,
    output logic [ADDR_W-1:0]    ram_address,
    output logic [BE_W-1:0]      ram_byteenable,
    output logic                 ram_chipselect,
    output logic                 ram_write,
    output logic [DATA_W-1:0]    ram_writedata,
    output logic                 ram_clken,
    input  logic [DATA_W-1:0]    ram_readdata
);

    logic [1:0]  req;
    logic [1:0]  grant;
    logic        grant_any;
    logic        in_range;
    ocm_req_t    m0_req;
    ocm_req_t    m1_req;
    ocm_req_t    sel;

    logic        last_q,     last_d;
    logic        rd_pend_q,  rd_pend_d;
    logic        rd_owner_q, rd_owner_d;
    logic        rd_oor_q,   rd_oor_d;
    logic [DATA_W-1:0] rd_data;

    assign req = {m1.read | m1.write, m0.read | m0.write};

    rr_arb2 u_arb (
        .req_i   (req),
        .last_i  (last_q),
        .grant_o (grant)
    );

    always_comb begin
        m0_req = '{address: m0.address, byteenable: m0.byteenable, read: m0.read,
                   write: m0.write, writedata: m0.writedata};
        m1_req = '{address: m1.address, byteenable: m1.byteenable, read: m1.read,
                   write: m1.write, writedata: m1.writedata};
        sel    = grant[1] ? m1_req : m0_req;
    end

    assign grant_any = |grant;
    assign in_range  = int'(sel.address) < NUM_WORDS;

    assign ram_address    = sel.address;
    assign ram_byteenable = sel.byteenable;
    assign ram_writedata  = sel.writedata;
    assign ram_chipselect = grant_any & in_range;
    assign ram_write      = grant_any & sel.write & in_range;
    assign ram_clken      = ~reset;

    // A write strobe wins over a simultaneous read strobe, so only pure reads return data.
    always_comb begin
        last_d     = last_q;
        if (grant_any) begin
            last_d = grant[1];
        end
        rd_pend_d  = grant_any & sel.read & ~sel.write;
        rd_owner_d = grant[1];
        rd_oor_d   = ~in_range;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q     <= 1'b1;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
            rd_oor_q   <= 1'b0;
        end else begin
            last_q     <= last_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            rd_oor_q   <= rd_oor_d;
        end
    end

    assign rd_data = rd_oor_q ? '0 : ram_readdata;

    assign m0.waitrequest = req[0] & ~grant[0];
    assign m1.waitrequest = req[1] & ~grant[1];

    // Gating with reset drops a return whose read was accepted just before reset rose.
    assign m0.readdatavalid = rd_pend_q & ~rd_owner_q & ~reset;
    assign m1.readdatavalid = rd_pend_q &  rd_owner_q & ~reset;
    assign m0.readdata      = rd_data;
    assign m1.readdata      = rd_data;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: behavioural RAM, reference model checked every cycle,
// directed scenarios with literal expectations followed by randomized traffic.
module tb_onchip_mem_arbiter;
    import onchip_mem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    onchip_mem_arbiter_if m0_if ();
    onchip_mem_arbiter_if m1_if ();

    logic [OCM_ADDR_W-1:0] ram_address;
    logic [OCM_BE_W-1:0]   ram_byteenable;
    logic                  ram_chipselect;
    logic                  ram_write;
    logic [OCM_DATA_W-1:0] ram_writedata;
    logic                  ram_clken;
    logic [OCM_DATA_W-1:0] ram_readdata;

    onchip_mem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .m0             (m0_if),
        .m1             (m1_if),
        .ram_address    (ram_address),
        .ram_byteenable (ram_byteenable),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_clken      (ram_clken),
        .ram_readdata   (ram_readdata)
    );

    // Behavioural single-port RAM with byte enables and 1-cycle read latency
    logic [31:0] ram_mem [0:OCM_NUM_WORDS-1] = '{default: 32'h0};
    always @(posedge clk) begin
        if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end else begin
                ram_readdata <= ram_mem[ram_address];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory image, last winner and the one outstanding read return
    logic [31:0] mdl_mem [0:OCM_NUM_WORDS-1] = '{default: 32'h0};
    int          m_last  = 1;
    bit          p_vld   = 0;
    int          p_owner = 0;
    logic [31:0] p_data  = 32'h0;

    always @(negedge clk) begin
        bit          r0, r1, wr, rd, inr;
        int          win;
        logic [14:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        r0 = m0_if.read | m0_if.write;
        r1 = m1_if.read | m1_if.write;
        if (reset) begin
            chk("clken_in_reset", ram_clken, 0);
            chk("rv0_in_reset", m0_if.readdatavalid, 0);
            chk("rv1_in_reset", m1_if.readdatavalid, 0);
            m_last = 1;
            p_vld  = 0;
        end else begin
            if (r0 && r1) win = (m_last == 0) ? 1 : 0;
            else if (r0)  win = 0;
            else if (r1)  win = 1;
            else          win = -1;
            chk("clken", ram_clken, 1);
            chk("wait0", m0_if.waitrequest, r0 && win != 0);
            chk("wait1", m1_if.waitrequest, r1 && win != 1);
            chk("rv0", m0_if.readdatavalid, p_vld && p_owner == 0);
            chk("rv1", m1_if.readdatavalid, p_vld && p_owner == 1);
            if (p_vld) begin
                chk("rdata0", m0_if.readdata, p_data);
                chk("rdata1", m1_if.readdata, p_data);
            end
            if (win >= 0) begin
                a   = (win == 0) ? m0_if.address    : m1_if.address;
                be  = (win == 0) ? m0_if.byteenable : m1_if.byteenable;
                wd  = (win == 0) ? m0_if.writedata  : m1_if.writedata;
                wr  = (win == 0) ? m0_if.write      : m1_if.write;
                rd  = (win == 0) ? m0_if.read       : m1_if.read;
                inr = int'(a) < OCM_NUM_WORDS;
                chk("ram_cs", ram_chipselect, inr);
                chk("ram_we", ram_write, wr && inr);
                if (inr) chk("ram_addr", ram_address, a);
                if (inr && wr) begin
                    chk("ram_wdata", ram_writedata, wd);
                    chk("ram_be", ram_byteenable, be);
                    for (int b = 0; b < 4; b++)
                        if (be[b]) mdl_mem[a][8*b +: 8] = wd[8*b +: 8];
                end
                m_last  = win;
                p_vld   = rd && !wr;
                p_owner = win;
                p_data  = inr ? mdl_mem[a] : 32'h0;
            end else begin
                chk("ram_cs_idle", ram_chipselect, 0);
                chk("ram_we_idle", ram_write, 0);
                p_vld = 0;
            end
        end
    end

    task automatic drv(input int m, input logic rd, input logic wr, input logic [14:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
        if (m == 0) begin
            m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
            m0_if.byteenable = be; m0_if.writedata = wd;
        end else begin
            m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
            m1_if.byteenable = be; m1_if.writedata = wd;
        end
    endtask

    task automatic idle_all();
        drv(0, 0, 0, 15'h0, 4'h0, 32'h0);
        drv(1, 0, 0, 15'h0, 4'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int k0, k1, first, prev, g;
    bit alt_ok;
    bit          act  [2];
    logic        rdv  [2];
    logic        wrv  [2];
    logic [14:0] adr  [2];
    logic [3:0]  bev  [2];
    logic [31:0] wdv  [2];

    initial begin
        reset = 1'b1;
        idle_all();
        repeat (3) @(posedge clk);

        // Single-master write then read
        tick(); reset = 1'b0;
        drv(0, 0, 1, 15'h0010, 4'hF, 32'hA5A5_1234);
        @(negedge clk); chk("t1_wr_wait", m0_if.waitrequest, 0);
        tick(); drv(0, 1, 0, 15'h0010, 4'hF, 32'h0);
        @(negedge clk); chk("t1_rd_wait", m0_if.waitrequest, 0);
        chk("t1_rv_early", m0_if.readdatavalid, 0);
        tick(); idle_all();
        @(negedge clk); chk("t1_rv", m0_if.readdatavalid, 1);
        chk("t1_rdata", m0_if.readdata, 32'hA5A5_1234);
        chk("t1_rv1", m1_if.readdatavalid, 0);

        // Tie directly after reset: m0 first
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        drv(0, 1, 0, 15'h0010, 4'hF, 32'h0);
        drv(1, 1, 0, 15'h0010, 4'hF, 32'h0);
        @(negedge clk); chk("t2_wait0", m0_if.waitrequest, 0);
        chk("t2_wait1", m1_if.waitrequest, 1);
        tick(); drv(0, 0, 0, 15'h0, 4'h0, 32'h0);
        @(negedge clk); chk("t2_wait1_b", m1_if.waitrequest, 0);
        chk("t2_rv0", m0_if.readdatavalid, 1);
        chk("t2_rdata0", m0_if.readdata, 32'hA5A5_1234);
        chk("t2_rv1_early", m1_if.readdatavalid, 0);
        tick(); idle_all();
        @(negedge clk); chk("t2_rv1", m1_if.readdatavalid, 1);
        chk("t2_rv0_late", m0_if.readdatavalid, 0);
        chk("t2_rdata1", m1_if.readdata, 32'hA5A5_1234);

        // Sustained write contention for 8 cycles
        k0 = 0; k1 = 0; first = -1; prev = -1; alt_ok = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            drv(0, 0, 1, 15'(32'h100 + k0), 4'hF, 32'h1000 + k0);
            drv(1, 0, 1, 15'(32'h200 + k1), 4'hF, 32'h2000 + k1);
            @(negedge clk);
            g = m0_if.waitrequest ? 1 : 0;
            if (!m0_if.waitrequest) k0++;
            if (!m1_if.waitrequest) k1++;
            if (c == 0) first = g;
            else if (g == prev) alt_ok = 1'b0;
            prev = g;
        end
        chk("t3_first_grant", first, 0);
        chk("t3_alternate", alt_ok, 1);
        chk("t3_m0_writes", k0, 4);
        chk("t3_m1_writes", k1, 4);

        // Byte enables and out-of-range accesses
        tick(); idle_all();
        drv(0, 0, 1, 15'h0300, 4'b0101, 32'hFFFF_FFFF);
        @(negedge clk); chk("t4_be_wait", m0_if.waitrequest, 0);
        tick(); drv(0, 1, 0, 15'h0300, 4'hF, 32'h0);
        tick(); drv(0, 1, 0, 15'd25000, 4'hF, 32'h0);
        @(negedge clk); chk("t4_oor_rd_cs", ram_chipselect, 0);
        chk("t4_oor_rd_wait", m0_if.waitrequest, 0);
        chk("t4_be_rv", m0_if.readdatavalid, 1);
        chk("t4_be_rdata", m0_if.readdata, 32'h00FF_00FF);
        tick(); drv(0, 0, 1, 15'd30000, 4'hF, 32'hDEAD_BEEF);
        @(negedge clk); chk("t4_oor_rv", m0_if.readdatavalid, 1);
        chk("t4_oor_rdata", m0_if.readdata, 32'h0);
        chk("t4_oor_wr_wait", m0_if.waitrequest, 0);
        chk("t4_oor_wr_cs", ram_chipselect, 0);
        chk("t4_oor_wr_we", ram_write, 0);

        // Reset right after an m1 read is accepted
        tick(); idle_all(); drv(1, 1, 0, 15'h0010, 4'hF, 32'h0);
        @(negedge clk); chk("t5_rd_wait", m1_if.waitrequest, 0);
        tick(); reset = 1'b1; idle_all();
        @(negedge clk); chk("t5_no_rv", m1_if.readdatavalid, 0);
        tick(); reset = 1'b0;
        drv(0, 1, 0, 15'h0100, 4'hF, 32'h0);
        drv(1, 1, 0, 15'h0203, 4'hF, 32'h0);
        @(negedge clk); chk("t5_wait0", m0_if.waitrequest, 0);
        chk("t5_wait1", m1_if.waitrequest, 1);
        tick(); drv(0, 0, 0, 15'h0, 4'h0, 32'h0);
        @(negedge clk); chk("t5_rdata0", m0_if.readdata, 32'h0000_1000);
        tick(); idle_all();
        @(negedge clk); chk("t5_rv1", m1_if.readdatavalid, 1);
        chk("t5_rdata1", m1_if.readdata, 32'h0000_2003);

        // Both strobes: treated as a write
        tick(); drv(0, 1, 1, 15'h0400, 4'hF, 32'h1234_5678);
        @(negedge clk); chk("t6_wait", m0_if.waitrequest, 0);
        tick(); idle_all();
        @(negedge clk); chk("t6_no_rv", m0_if.readdatavalid, 0);
        tick(); drv(0, 1, 0, 15'h0400, 4'hF, 32'h0);
        tick(); idle_all();
        @(negedge clk); chk("t6_readback", m0_if.readdata, 32'h1234_5678);

        // Randomized traffic, requests held while waitrequest is high
        act[0] = 0; act[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset = ($urandom_range(0, 299) == 0);
            for (int m = 0; m < 2; m++) begin
                if (reset) begin
                    act[m] = 0;
                end else if (!act[m] && $urandom_range(0, 99) < 65) begin
                    int t;
                    act[m] = 1;
                    t = $urandom_range(0, 9);
                    rdv[m] = (t < 5) || (t == 9);
                    wrv[m] = (t >= 5);
                    adr[m] = ($urandom_range(0, 9) == 0) ? 15'(24998 + $urandom_range(0, 7))
                                                         : 15'($urandom_range(0, 15));
                    bev[m] = 4'($urandom_range(0, 15));
                    wdv[m] = $urandom;
                end
                if (act[m]) drv(m, rdv[m], wrv[m], adr[m], bev[m], wdv[m]);
                else        drv(m, 0, 0, 15'h0, 4'h0, 32'h0);
            end
            @(negedge clk);
            if (act[0] && !reset && !m0_if.waitrequest) act[0] = 0;
            if (act[1] && !reset && !m1_if.waitrequest) act[1] = 0;
        end

        tick(); reset = 1'b0; idle_all();
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
